// File: rtl/cpu_result_logger.sv
// Change-logging FIFO for the CPU result/zero/carry outputs, with a handshake output stream.
// Optional CPU_RESULT_LOGGER_TIMESTAMP_EN adds a 16-bit capture timestamp (out_stamp).
module cpu_result_logger #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_zero,
    input  logic                     in_carry,
    input  logic                     cap_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_zero,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic [CNT_W-1:0]         change_cnt,
`ifdef CPU_RESULT_LOGGER_TIMESTAMP_EN
    output logic [15:0]              out_stamp,
`endif
    output logic                     state_dbg
);
    // Handshake: an entry transfers at a rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready and the head stays stable until taken.

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int TW = WIDTH + 2;
`ifdef CPU_RESULT_LOGGER_TIMESTAMP_EN
    localparam int EW = TW + 16;
`else
    localparam int EW = TW;
`endif
    localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

    typedef enum logic {
        EMPTY_HIST = 1'b0,
        TRACKING   = 1'b1
    } state_t;

    state_t           state;
    logic [TW-1:0]    last_tuple;
    logic [TW-1:0]    cur_tuple;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    entry_in;
    logic [EW-1:0]    head_q;
    logic [EW-1:0]    head_next;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_next;
    logic             change;
    logic             push;
    logic             pop;

`ifdef CPU_RESULT_LOGGER_TIMESTAMP_EN
    logic [15:0]      cycle_cnt;

    always_ff @(posedge clk) begin
        if (!rst) cycle_cnt <= '0;
        else      cycle_cnt <= cycle_cnt + 16'd1;
    end

    assign entry_in  = {cycle_cnt, cur_tuple};
    assign out_stamp = head_q[EW-1 -: 16];
`else
    assign entry_in  = cur_tuple;
`endif

    assign cur_tuple  = {in_result, in_zero, in_carry};
    assign out_valid  = (fill_q != '0);
    assign out_result = head_q[TW-1:2];
    assign out_zero   = head_q[1];
    assign out_carry  = head_q[0];
    assign fill       = fill_q;
    assign state_dbg  = state;

    always_comb begin
        change    = cap_en && ((state == EMPTY_HIST) || (cur_tuple != last_tuple));
        pop       = out_valid && out_ready;
        push      = change && ((fill_q != DEPTH_F) || pop);
        rd_next   = rd_ptr + AW'(pop);
        fill_next = fill_q + FW'(push) - FW'(pop);
        // The new head is the incoming entry only when it lands exactly at the next read slot.
        if (push && (rd_next == wr_ptr)) head_next = entry_in;
        else                             head_next = mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= EMPTY_HIST;
            last_tuple <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            overflow   <= 1'b0;
            change_cnt <= '0;
        end else begin
            if (change) begin
                state      <= TRACKING;
                last_tuple <= cur_tuple;
                if (change_cnt != '1) change_cnt <= change_cnt + 1'b1;
                if (!push) overflow <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_next;
            fill_q <= fill_next;
            if (fill_next != '0) head_q <= head_next;
        end
    end

endmodule

// File: tb/tb_cpu_result_logger.sv
// Scoreboard bench for cpu_result_logger: directed vectors push expected entries, a monitor checks pops.
module tb_cpu_result_logger;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int TW    = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] in_result = '0;
    logic             in_zero = 1'b0;
    logic             in_carry = 1'b0;
    logic             cap_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_carry;
    logic [3:0]       fill;
    logic             overflow;
    logic [CNT_W-1:0] change_cnt;
    logic             state_dbg;
`ifdef CPU_RESULT_LOGGER_TIMESTAMP_EN
    logic [15:0]      out_stamp;
`endif

    logic [TW-1:0]    exp_q[$];
    logic [TW-1:0]    last_pop = '0;
    int               checks = 0;
    int               errors = 0;

    cpu_result_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_result(in_result), .in_zero(in_zero),
        .in_carry(in_carry), .cap_en(cap_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_carry(out_carry), .fill(fill), .overflow(overflow),
        .change_cnt(change_cnt),
`ifdef CPU_RESULT_LOGGER_TIMESTAMP_EN
        .out_stamp(out_stamp),
`endif
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        cap_en = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) tick();
        rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drivers
    task automatic drive(input logic [3:0] res, input logic z, input logic c, input bit logged);
        in_result = res;
        in_zero = z;
        in_carry = c;
        cap_en = 1'b1;
        if (logged) exp_q.push_back({res, z, c});
        tick();
    endtask

    task automatic drain();
        int n;
        cap_en = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left expected 0", exp_q.size());
        end
        out_ready = 1'b0;
        check("drain_fill", 32'(fill), 0);
        check("drain_hold", 32'({out_result, out_zero, out_carry}), 32'(last_pop));
    endtask

    // monitor / scoreboard
    initial begin
        logic [TW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got %0h expected none", {out_result, out_zero, out_carry});
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_result, out_zero, out_carry} !== exp) begin
                        errors++;
                        $display("FAIL pop_data: got %0h expected %0h", {out_result, out_zero, out_carry}, exp);
                    end
                end
                last_pop = {out_result, out_zero, out_carry};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        // reset then first sample
        do_reset(2);
        check("rst_fill", 32'(fill), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_result", 32'(out_result), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_cnt", 32'(change_cnt), 0);
        check("rst_state", 32'(state_dbg), 0);
        drive(4'b0000, 1'b1, 1'b0, 1'b1);
        check("first_fill", 32'(fill), 1);
        check("first_valid", 32'(out_valid), 1);
        check("first_result", 32'(out_result), 0);
        check("first_zero", 32'(out_zero), 1);
        check("first_cnt", 32'(change_cnt), 1);
        check("first_state", 32'(state_dbg), 1);
        drain();

        // change filtering
        do_reset(1);
        drive(4'b0011, 1'b0, 1'b0, 1'b1);
        repeat (4) drive(4'b0011, 1'b0, 1'b0, 1'b0);
        drive(4'b0101, 1'b0, 1'b1, 1'b1);
        check("filt_fill", 32'(fill), 2);
        check("filt_cnt", 32'(change_cnt), 2);
        check("filt_head", 32'(out_result), 32'h3);
        drain();

        // backpressure, overflow, then full with simultaneous push/pop
        do_reset(1);
        for (int i = 1; i <= 8; i++) drive(4'(i), 1'b0, 1'b0, 1'b1);
        check("full_fill", 32'(fill), 8);
        check("full_ovf", 32'(overflow), 0);
        drive(4'b1001, 1'b0, 1'b0, 1'b0);
        check("drop_ovf", 32'(overflow), 1);
        check("drop_fill", 32'(fill), 8);
        check("drop_cnt", 32'(change_cnt), 9);
        out_ready = 1'b1;
        drive(4'b1111, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b0;
        cap_en = 1'b0;
        check("pp_fill", 32'(fill), 8);
        check("pp_ovf", 32'(overflow), 1);
        check("pp_cnt", 32'(change_cnt), 10);
        drain();

        // reset mid-stream
        do_reset(1);
        for (int i = 1; i <= 5; i++) drive(4'(i), 1'b0, 1'b0, 1'b1);
        check("mid_fill", 32'(fill), 5);
        do_reset(1);
        check("mid_rst_fill", 32'(fill), 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_cnt", 32'(change_cnt), 0);
        drive(4'b0101, 1'b0, 1'b0, 1'b1);
        check("mid_relog_fill", 32'(fill), 1);
        drain();

        // CPU-like result stream consumed concurrently
        do_reset(1);
        out_ready = 1'b1;
        drive(4'b0001, 1'b0, 1'b0, 1'b1);
        drive(4'b0001, 1'b0, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0, 1'b1);
        drive(4'b0011, 1'b0, 1'b0, 1'b1);
        drive(4'b0011, 1'b0, 1'b0, 1'b0);
        drive(4'b0011, 1'b0, 1'b0, 1'b0);
        drain();
        check("cpu_last", 32'(last_pop), 32'({4'b0011, 2'b00}));
        check("cpu_cnt", 32'(change_cnt), 3);
        check("cpu_ovf", 32'(overflow), 0);

        // counter saturation
        do_reset(1);
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) drive(4'(i), 1'b0, 1'b1, 1'b1);
        drain();
        check("sat_cnt", 32'(change_cnt), 255);
        check("sat_ovf", 32'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
